multiplier_arbiter: RTL and testbench

//  Shares one 8x8 sequential multiplier (start/done handshake) between NUM_REQ requesters.

---
 rtl/multiplier_arbiter_pkg.sv | 29 ++
 rtl/multiplier_arbiter_if.sv | 37 +++
 rtl/multiplier_arbiter_picker.sv | 39 +++
 rtl/multiplier_arbiter.sv | 192 +++++++++++++++++++
 tb/tb_multiplier_arbiter.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/multiplier_arbiter_pkg.sv
// Shared types and helpers for the multiplier arbiter: FSM encoding,
// default widths and the round-robin pointer step.
package multiplier_arbiter_pkg;

  localparam int MA_NUM_REQ = 4;
  localparam int MA_DATA_W  = 8;
  localparam int MA_PROD_W  = 2 * MA_DATA_W;
  localparam int MA_TIMEOUT = 15;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_GRANT   = 3'd1,
    ST_WAIT    = 3'd2,
    ST_DELIVER = 3'd3,
    ST_RECOVER = 3'd4
  } arb_state_t;

  // Pointer moves to the requester after the one just served, wrapping at num_req.
  function automatic logic [2:0] rr_next(input logic [2:0] idx, input logic [3:0] num_req);
    logic [2:0] w_next;
    if ({1'b0, idx} == (num_req - 4'd1)) begin
      w_next = 3'd0;
    end else begin
      w_next = idx + 3'd1;
    end
    return w_next;
  endfunction

endpackage

// File: rtl/multiplier_arbiter_if.sv
// Requester-side and multiplier-side signals of the arbiter in one bundle.
// The arbiter uses the slave view; the surrounding system uses the master view.
interface multiplier_arbiter_if
  import multiplier_arbiter_pkg::*;
#(
  parameter int NUM_REQ = MA_NUM_REQ,
  parameter int DATA_W  = MA_DATA_W
) ();

  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*DATA_W-1:0] req_a;
  logic [NUM_REQ*DATA_W-1:0] req_b;
  logic [NUM_REQ-1:0]        grant;
  logic [NUM_REQ-1:0]        resp_valid;
  logic                      resp_err;
  logic [2*DATA_W-1:0]       resp_product;
  logic                      busy;
  logic                      mul_start;
  logic [DATA_W-1:0]         mul_dataa;
  logic [DATA_W-1:0]         mul_datab;
  logic                      mul_reset;
  logic                      mul_done;
  logic [2*DATA_W-1:0]       mul_product;

  modport slave (
    input  req, req_a, req_b, mul_done, mul_product,
    output grant, resp_valid, resp_err, resp_product, busy,
           mul_start, mul_dataa, mul_datab, mul_reset
  );

  modport master (
    output req, req_a, req_b, mul_done, mul_product,
    input  grant, resp_valid, resp_err, resp_product, busy,
           mul_start, mul_dataa, mul_datab, mul_reset
  );

endinterface

// File: rtl/multiplier_arbiter_picker.sv
// Round-robin priority picker: first eligible requester at or after the
// pointer, wrapping, with the masked requester excluded.
module rr_priority_picker
  import multiplier_arbiter_pkg::*;
#(
  parameter int NUM_REQ = MA_NUM_REQ,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [NUM_REQ-1:0] i_mask,
  input  logic [IDX_W-1:0]   i_ptr,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [IDX_W-1:0]   o_index,
  output logic               o_any
);

  logic [NUM_REQ-1:0] w_eligible;
  logic [IDX_W-1:0]   w_slot;
  logic               w_hit;

  assign w_eligible = i_req & ~i_mask;

  // Scan slots ptr, ptr+1, ... and keep the first eligible hit.
  always_comb begin
    o_grant = '0;
    o_index = '0;
    o_any   = 1'b0;
    w_slot  = '0;
    w_hit   = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_slot  = IDX_W'((int'(i_ptr) + k) % NUM_REQ);
      w_hit   = !o_any && w_eligible[w_slot];
      o_index = w_hit ? w_slot : o_index;
      o_grant = w_hit ? (NUM_REQ'(1'b1) << w_slot) : o_grant;
      o_any   = o_any | w_hit;
    end
  end

endmodule

// File: rtl/multiplier_arbiter.sv
// Shares one sequential multiplier between NUM_REQ requesters: round-robin
// grant, a single op in flight, and a watchdog that aborts a hung multiplier.
module multiplier_arbiter
  import multiplier_arbiter_pkg::*;
#(
  parameter int NUM_REQ = MA_NUM_REQ,
  parameter int DATA_W  = MA_DATA_W,
  parameter int TIMEOUT = MA_TIMEOUT
) (
  input  logic                 clk,
  input  logic                 reset_a,
  multiplier_arbiter_if.slave  bus
);

  localparam int IDX_W  = $clog2(NUM_REQ);
  localparam int PROD_W = 2 * DATA_W;
  localparam int CNT_W  = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  arb_state_t          r_state;
  arb_state_t          w_state_next;
  logic [IDX_W-1:0]    r_ptr;
  logic [IDX_W-1:0]    r_owner;
  logic [NUM_REQ-1:0]  r_mask;
  logic [CNT_W-1:0]    r_cnt;

  logic [NUM_REQ-1:0]  w_pick_onehot;
  logic [IDX_W-1:0]    w_pick_idx;
  logic                w_pick_any;

  logic [NUM_REQ-1:0]  r_grant;
  logic [NUM_REQ-1:0]  r_resp_valid;
  logic                r_resp_err;
  logic [PROD_W-1:0]   r_resp_product;
  logic                r_busy;
  logic                r_mul_start;
  logic [DATA_W-1:0]   r_mul_dataa;
  logic [DATA_W-1:0]   r_mul_datab;
  logic                r_mul_reset;

  logic [NUM_REQ-1:0]  w_grant_next;
  logic [NUM_REQ-1:0]  w_resp_valid_next;
  logic [PROD_W-1:0]   w_product_next;
  logic [DATA_W-1:0]   w_dataa_next;
  logic [DATA_W-1:0]   w_datab_next;

  rr_priority_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .i_req   (bus.req),
    .i_mask  (r_mask),
    .i_ptr   (r_ptr),
    .o_grant (w_pick_onehot),
    .o_index (w_pick_idx),
    .o_any   (w_pick_any)
  );

  // mul_done takes priority over a watchdog expiry in the same cycle.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_pick_any) begin
          w_state_next = ST_GRANT;
        end else begin
          w_state_next = ST_IDLE;
        end
      end
      ST_GRANT: w_state_next = ST_WAIT;
      ST_WAIT: begin
        if (bus.mul_done) begin
          w_state_next = ST_DELIVER;
        end else if (r_cnt == CNT_LAST) begin
          w_state_next = ST_RECOVER;
        end else begin
          w_state_next = ST_WAIT;
        end
      end
      ST_DELIVER: w_state_next = ST_IDLE;
      ST_RECOVER: w_state_next = ST_IDLE;
      default:    w_state_next = ST_IDLE;
    endcase
  end

  // Outputs are registered, so their next values follow the next state.
  always_comb begin
    w_grant_next      = '0;
    w_resp_valid_next = '0;
    w_product_next    = '0;
    w_dataa_next      = '0;
    w_datab_next      = '0;
    case (w_state_next)
      ST_GRANT: begin
        w_grant_next = w_pick_onehot;
        w_dataa_next = bus.req_a[int'(w_pick_idx) * DATA_W +: DATA_W];
        w_datab_next = bus.req_b[int'(w_pick_idx) * DATA_W +: DATA_W];
      end
      ST_WAIT: begin
        w_grant_next = r_grant;
        w_dataa_next = r_mul_dataa;
        w_datab_next = r_mul_datab;
      end
      ST_DELIVER: begin
        w_grant_next      = r_grant;
        w_resp_valid_next = r_grant;
        w_product_next    = bus.mul_product;
      end
      ST_RECOVER: begin
        w_grant_next      = r_grant;
        w_resp_valid_next = r_grant;
      end
      default: begin
        w_grant_next      = '0;
        w_resp_valid_next = '0;
      end
    endcase
  end

  // State and output registers; the mask remembers last cycle's responder.
  always_ff @(posedge clk) begin
    if (reset_a) begin
      r_state        <= ST_IDLE;
      r_grant        <= '0;
      r_resp_valid   <= '0;
      r_resp_err     <= 1'b0;
      r_resp_product <= '0;
      r_busy         <= 1'b0;
      r_mul_start    <= 1'b0;
      r_mul_dataa    <= '0;
      r_mul_datab    <= '0;
      r_mul_reset    <= 1'b0;
      r_mask         <= '0;
    end else begin
      r_state        <= w_state_next;
      r_grant        <= w_grant_next;
      r_resp_valid   <= w_resp_valid_next;
      r_resp_err     <= (w_state_next == ST_RECOVER);
      r_resp_product <= w_product_next;
      r_busy         <= (w_state_next != ST_IDLE);
      r_mul_start    <= (w_state_next == ST_GRANT);
      r_mul_dataa    <= w_dataa_next;
      r_mul_datab    <= w_datab_next;
      r_mul_reset    <= (w_state_next == ST_RECOVER);
      r_mask         <= r_resp_valid;
    end
  end

  // Owner latched at grant; pointer advances once the owner is answered.
  always_ff @(posedge clk) begin
    if (reset_a) begin
      r_owner <= '0;
      r_ptr   <= '0;
    end else begin
      if ((r_state == ST_IDLE) && w_pick_any) begin
        r_owner <= w_pick_idx;
      end
      if ((r_state == ST_DELIVER) || (r_state == ST_RECOVER)) begin
        r_ptr <= IDX_W'(rr_next(3'(r_owner), 4'(NUM_REQ)));
      end
    end
  end

  // Watchdog: cleared at grant, saturating count of WAIT cycles.
  always_ff @(posedge clk) begin
    if (reset_a) begin
      r_cnt <= '0;
    end else begin
      case (r_state)
        ST_GRANT: r_cnt <= '0;
        ST_WAIT: begin
          if (r_cnt != CNT_MAX) begin
            r_cnt <= r_cnt + CNT_W'(1'b1);
          end
        end
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  assign bus.grant        = r_grant;
  assign bus.resp_valid   = r_resp_valid;
  assign bus.resp_err     = r_resp_err;
  assign bus.resp_product = r_resp_product;
  assign bus.busy         = r_busy;
  assign bus.mul_start    = r_mul_start;
  assign bus.mul_dataa    = r_mul_dataa;
  assign bus.mul_datab    = r_mul_datab;
  assign bus.mul_reset    = r_mul_reset;

endmodule

// File: tb/tb_multiplier_arbiter.sv
// Directed and randomized bench for multiplier_arbiter against a cycle-level
// reference of the round-robin, watchdog and response rules.
module tb_multiplier_arbiter;

  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 8;
  localparam int TIMEOUT = 15;

  logic clk;
  logic reset_a;

  logic [NUM_REQ-1:0] t_req;
  logic [DATA_W-1:0]  t_a [NUM_REQ];
  logic [DATA_W-1:0]  t_b [NUM_REQ];
  logic               t_done;
  logic [15:0]        t_prod;

  int n_pass;
  int n_fail;
  int n_total;
  int m_ptr;
  int m_mask;

  multiplier_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) bus ();

  assign bus.req         = t_req;
  assign bus.req_a       = {t_a[3], t_a[2], t_a[1], t_a[0]};
  assign bus.req_b       = {t_b[3], t_b[2], t_b[1], t_b[0]};
  assign bus.mul_done    = t_done;
  assign bus.mul_product = t_prod;

  multiplier_arbiter #(
    .NUM_REQ (NUM_REQ),
    .DATA_W  (DATA_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk     (clk),
    .reset_a (reset_a),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NUM_REQ-1:0] onehot(input int i);
    logic [NUM_REQ-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  // Reference rule: first requester at or after ptr (wrapping), skipping the masked one.
  function automatic int model_pick(input logic [NUM_REQ-1:0] r, input int ptr, input int mask);
    for (int k = 0; k < NUM_REQ; k++) begin
      int i;
      i = (ptr + k) % NUM_REQ;
      if (r[i] && (i != mask)) return i;
    end
    return -1;
  endfunction

  // One arbitration from an IDLE negedge; lat = WAIT cycle carrying mul_done, 0 = never.
  task automatic serve(input int lat, input bit drop);
    int e;
    bit delivered;
    logic [15:0] exp_p;
    e = model_pick(t_req, m_ptr, m_mask);
    m_mask = -1;
    if (e < 0) begin
      tick();
      check("idle_busy", 32'(bus.busy), 32'd0);
      e = model_pick(t_req, m_ptr, m_mask);
      if (e < 0) begin
        tick();
        check("idle_busy2", 32'(bus.busy), 32'd0);
        return;
      end
    end
    exp_p = 16'(t_a[e]) * 16'(t_b[e]);
    delivered = (lat >= 1) && (lat <= TIMEOUT);
    tick();
    check("start", 32'(bus.mul_start), 32'd1);
    check("grant", 32'(bus.grant), 32'(onehot(e)));
    check("opa", 32'(bus.mul_dataa), 32'(t_a[e]));
    check("opb", 32'(bus.mul_datab), 32'(t_b[e]));
    check("busy", 32'(bus.busy), 32'd1);
    for (int w = 1; w <= TIMEOUT; w++) begin
      tick();
      check("wait_ctl", 32'({bus.mul_start, bus.mul_reset, bus.resp_valid}), 32'd0);
      check("wait_own", 32'({bus.grant, bus.mul_dataa, bus.mul_datab}),
            32'({onehot(e), t_a[e], t_b[e]}));
      if (w == lat) begin
        t_done = 1'b1;
        t_prod = 16'(bus.mul_dataa) * 16'(bus.mul_datab);
        break;
      end
    end
    tick();
    t_done = 1'b0;
    t_prod = 16'hBEEF;
    check("resp_valid", 32'(bus.resp_valid), 32'(onehot(e)));
    check("resp_grant", 32'(bus.grant), 32'(onehot(e)));
    check("resp_err", 32'(bus.resp_err), delivered ? 32'd0 : 32'd1);
    check("mul_reset", 32'(bus.mul_reset), delivered ? 32'd0 : 32'd1);
    check("product", 32'(bus.resp_product), delivered ? 32'(exp_p) : 32'd0);
    m_ptr  = (e + 1) % NUM_REQ;
    m_mask = e;
    if (drop) t_req[e] = 1'b0;
    tick();
    check("after_idle", 32'({bus.busy, bus.resp_valid, bus.mul_reset, bus.grant}), 32'd0);
  endtask

  initial begin
    n_pass = 0;
    n_fail = 0;
    n_total = 0;
    m_ptr = 0;
    m_mask = -1;
    t_req = '0;
    t_done = 1'b0;
    t_prod = 16'hBEEF;
    for (int i = 0; i < NUM_REQ; i++) begin
      t_a[i] = '0;
      t_b[i] = '0;
    end
    reset_a = 1'b1;
    repeat (3) tick();
    check("rst_ctl", 32'({bus.grant, bus.resp_valid, bus.resp_err, bus.busy, bus.mul_start, bus.mul_reset}), 32'd0);
    check("rst_data", {bus.mul_dataa, bus.mul_datab, bus.resp_product}, 32'd0);
    reset_a = 1'b0;

    // Basic op: 13*11.
    t_a[0] = 8'd13; t_b[0] = 8'd11; t_req = 4'b0001;
    serve(5, 1'b1);

    // Product boundaries.
    t_a[0] = 8'd255; t_b[0] = 8'd255; t_req[0] = 1'b1;
    serve(3, 1'b1);
    t_a[2] = 8'd0; t_b[2] = 8'd200; t_req[2] = 1'b1;
    serve(2, 1'b1);

    // Two requesters re-requesting: alternate 0,2,0,2.
    for (int i = 0; i < NUM_REQ; i++) begin
      t_a[i] = 8'($urandom_range(0, 255));
      t_b[i] = 8'($urandom_range(0, 255));
    end
    m_ptr = 0;
    t_req = 4'b0101;
    for (int k = 0; k < 4; k++) serve(int'($urandom_range(1, 8)), 1'b0);
    t_req = '0;
    tick();
    m_mask = -1;

    // Hung multiplier, then the next request is still served.
    t_req[1] = 1'b1;
    serve(0, 1'b1);
    t_req[2] = 1'b1;
    serve(4, 1'b1);

    // mul_done on the last permitted WAIT cycle wins.
    t_req[3] = 1'b1;
    serve(TIMEOUT, 1'b1);

    // mul_done while idle is ignored.
    t_done = 1'b1; t_prod = 16'h1234;
    tick();
    t_done = 1'b0; t_prod = 16'hBEEF;
    check("stray_done", 32'({bus.busy, bus.resp_valid}), 32'd0);
    tick();
    check("stray_done2", 32'({bus.busy, bus.resp_valid, bus.mul_start}), 32'd0);
    m_mask = -1;

    // Random traffic.
    for (int it = 0; it < 14; it++) begin
      int lat;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!t_req[i] && ($urandom_range(0, 1) == 1)) begin
          t_req[i] = 1'b1;
          t_a[i] = 8'($urandom_range(0, 255));
          t_b[i] = 8'($urandom_range(0, 255));
        end
      end
      lat = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, TIMEOUT));
      serve(lat, 1'b1);
    end
    t_req = '0;
    repeat (2) tick();
    m_mask = -1;

    // Reset in the middle of WAIT drops the op and clears the pointer.
    t_a[1] = 8'd7; t_b[1] = 8'd9; t_req = 4'b0010;
    serve(2, 1'b1);
    t_a[3] = 8'd21; t_b[3] = 8'd3; t_req = 4'b1000;
    tick();
    check("pre_rst_start", 32'({bus.mul_start, bus.grant}), 32'({1'b1, 4'b1000}));
    repeat (2) tick();
    reset_a = 1'b1;
    tick();
    check("mid_rst_ctl", 32'({bus.grant, bus.resp_valid, bus.resp_err, bus.busy, bus.mul_start, bus.mul_reset}), 32'd0);
    check("mid_rst_data", {bus.mul_dataa, bus.mul_datab, bus.resp_product}, 32'd0);
    reset_a = 1'b0;
    t_a[1] = 8'd100; t_b[1] = 8'd3; t_req = 4'b1010;
    m_ptr = 0;
    m_mask = -1;
    serve(3, 1'b1);
    serve(3, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
